// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: pipeline types and constants shared by fetch, stall/flush controller and pipeline regs
package if_fetch_unit_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DISCARD, READY} fetch_state_t;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int SF_STALL = 0;
  localparam int SF_FLUSH = 1;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: Wishbone classic read port between fetch stage and instruction memory
interface if_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic cyc, stb, we, ack;
  logic [DATA_WIDTH/8-1:0] sel;
  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat;
  modport master(output cyc, stb, we, sel, adr, input dat, ack);
  modport slave(input cyc, stb, we, sel, adr, output dat, ack);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner running a single-outstanding Wishbone fetch into the IF/ID register
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            pc_sf_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  if_fetch_unit_if.master       wb,
  output logic                  im_busy_o,
  output logic [ADDR_WIDTH-1:0] ifid_pc_o,
  output logic [DATA_WIDTH-1:0] ifid_inst_o,
  output logic                  ifid_valid_o
);
  fetch_state_t state;
  logic [ADDR_WIDTH-1:0] pc, saved, tgt, pc_inc;
  logic busy, flush, stall;
  assign flush = pc_sf_i[SF_FLUSH];
  assign stall = pc_sf_i[SF_STALL];
  assign tgt = branch_target_i & ~ADDR_WIDTH'(3);
  assign pc_inc = pc + ADDR_WIDTH'(4);
  // pc only moves when leaving a bus cycle, so it doubles as the stable fetch address
  assign wb.cyc = busy;
  assign wb.stb = busy;
  assign wb.we = 1'b0;
  assign wb.sel = '1;
  assign wb.adr = pc;
  assign im_busy_o = busy;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc <= PC_ADDR;
      saved <= PC_ADDR;
      busy <= 1'b0;
      ifid_valid_o <= 1'b0;
      ifid_inst_o <= DATA_WIDTH'(NOP_INST);
      ifid_pc_o <= PC_ADDR;
    end else
      case (state)
        IDLE: begin
          state <= FETCH;
          busy <= 1'b1;
          if (flush) pc <= tgt;
        end
        FETCH:
          if (wb.ack) begin
            busy <= 1'b0;
            state <= flush ? IDLE : READY;
            ifid_valid_o <= !flush;
            if (flush) pc <= tgt;
            else begin
              ifid_inst_o <= wb.dat;
              ifid_pc_o <= pc;
            end
          end else if (flush) begin
            saved <= tgt;
            state <= DISCARD;
          end
        DISCARD: begin
          if (flush) saved <= tgt;
          if (wb.ack) begin
            busy <= 1'b0;
            pc <= flush ? tgt : saved;
            state <= IDLE;
          end
        end
        READY:
          if (flush || !stall) begin
            state <= IDLE;
            ifid_valid_o <= 1'b0;
            ifid_inst_o <= DATA_WIDTH'(NOP_INST);
            pc <= flush ? tgt : pc_inc;
          end
      endcase
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized fetch transactions checked against a transaction-level PC model
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] sf = 2'b00, sf2 = 2'b00;
  logic [31:0] bt = 32'h0, bt2 = 32'h0;
  logic busy, valid, busy2, valid2;
  logic [31:0] ipc, inst, ipc2, inst2;
  logic [31:0] exp_pc = 32'h8000_0000, last_ipc = 32'h8000_0000;
  int errs = 0, checks = 0;
  if_fetch_unit_if wb();
  if_fetch_unit_if wb2();
  always #5 clk = ~clk;
  if_fetch_unit dut(.clk(clk), .reset(reset), .pc_sf_i(sf), .branch_target_i(bt), .wb(wb),
                    .im_busy_o(busy), .ifid_pc_o(ipc), .ifid_inst_o(inst), .ifid_valid_o(valid));
  if_fetch_unit #(.PC_ADDR(32'hFFFF_FFFC)) dut2(.clk(clk), .reset(reset), .pc_sf_i(sf2),
                    .branch_target_i(bt2), .wb(wb2), .im_busy_o(busy2), .ifid_pc_o(ipc2),
                    .ifid_inst_o(inst2), .ifid_valid_o(valid2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_fetch;
    int n = 0;
    sf = 2'b00;
    do begin
      @(negedge clk);
      wb.ack = 1'b0;
      n++;
    end while (!wb.cyc && n < 10);
    chk("fetch_start", {31'b0, wb.cyc}, 1);
    chk("idle_len", n, 1);
    chk("fetch_adr", wb.adr, exp_pc);
    chk("fetch_stb", {31'b0, wb.stb}, 1);
    chk("fetch_busy", {31'b0, busy}, 1);
    chk("fetch_valid", {31'b0, valid}, 0);
  endtask
  // scen: 0 retire +4, 1 flush in READY (st adds stall), 2 flush before ack (st adds a second flush), 3 flush with ack
  task automatic xact(input int scen, input int w, input logic [31:0] d, input logic [31:0] t1,
                      input logic [31:0] t2, input int hold, input logic st);
    logic [31:0] a;
    wait_fetch();
    a = exp_pc;
    for (int i = 0; i < w; i++) begin
      sf = {1'b0, 1'($urandom_range(0, 1))};
      @(negedge clk);
      chk("wait_cyc", {31'b0, wb.cyc}, 1);
      chk("wait_adr", wb.adr, a);
      chk("wait_valid", {31'b0, valid}, 0);
    end
    if (scen <= 1) begin
      sf = 2'b00; wb.ack = 1'b1; wb.dat = d;
      @(negedge clk);
      wb.ack = 1'b0;
      last_ipc = a;
      chk("valid", {31'b0, valid}, 1);
      chk("inst", inst, d);
      chk("ifid_pc", ipc, a);
      chk("ready_cyc", {31'b0, wb.cyc}, 0);
      chk("ready_busy", {31'b0, busy}, 0);
      for (int i = 0; i < hold; i++) begin
        sf = 2'b01; wb.ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("hold_valid", {31'b0, valid}, 1);
        chk("hold_inst", inst, d);
        chk("hold_pc", ipc, a);
        chk("hold_cyc", {31'b0, wb.cyc}, 0);
      end
      wb.ack = 1'b0; bt = t1;
      sf = scen == 1 ? {1'b1, st} : 2'b00;
      @(negedge clk);
      exp_pc = scen == 1 ? (t1 & ~32'h3) : a + 32'h4;
    end else if (scen == 2) begin
      sf = {1'b1, 1'($urandom_range(0, 1))}; bt = t1;
      @(negedge clk);
      exp_pc = t1 & ~32'h3;
      chk("disc_cyc", {31'b0, wb.cyc}, 1);
      chk("disc_busy", {31'b0, busy}, 1);
      chk("disc_adr", wb.adr, a);
      if (st) begin
        sf = 2'b10; bt = t2;
        @(negedge clk);
        exp_pc = t2 & ~32'h3;
        chk("disc2_cyc", {31'b0, wb.cyc}, 1);
      end
      for (int i = 0; i < hold; i++) begin
        sf = {1'b0, 1'($urandom_range(0, 1))};
        @(negedge clk);
        chk("disc_valid", {31'b0, valid}, 0);
        chk("disc_hold_cyc", {31'b0, wb.cyc}, 1);
      end
      sf = 2'b00; wb.ack = 1'b1; wb.dat = d;
      @(negedge clk);
      wb.ack = 1'b0;
    end else begin
      sf = 2'b10; bt = t1; wb.ack = 1'b1; wb.dat = d;
      @(negedge clk);
      wb.ack = 1'b0;
      exp_pc = t1 & ~32'h3;
    end
    sf = 2'b00;
    chk("exit_valid", {31'b0, valid}, 0);
    chk("exit_inst", inst, NOP_INST);
    chk("exit_cyc", {31'b0, wb.cyc}, 0);
    chk("exit_busy", {31'b0, busy}, 0);
    chk("exit_ipc", ipc, last_ipc);
    wb.ack = 1'($urandom_range(0, 1));
  endtask
  initial begin
    wb.ack = 1'b0; wb.dat = 32'h0; wb2.ack = 1'b0; wb2.dat = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_cyc", {31'b0, wb.cyc}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_inst", inst, NOP_INST);
    chk("rst_ipc", ipc, 32'h8000_0000);
    chk("rst_adr", wb.adr, 32'h8000_0000);
    chk("we", {31'b0, wb.we}, 0);
    chk("sel", {28'b0, wb.sel}, 32'hF);
    reset = 1'b0;
    xact(0, 2, 32'h0010_0093, 32'h0, 32'h0, 5, 1'b0);
    xact(2, 0, $urandom, 32'h8000_0100, 32'h0, 2, 1'b0);
    xact(3, 1, $urandom, 32'h8000_0200, 32'h0, 0, 1'b0);
    xact(1, 0, $urandom, 32'h8000_0040, 32'h0, 0, 1'b1);
    for (int k = 0; k < 150; k++)
      xact(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    wait_fetch();
    // second instance has sat in its first fetch since reset; finish it to exercise PC wrap
    chk("wrap_cyc", {31'b0, wb2.cyc}, 1);
    chk("wrap_adr0", wb2.adr, 32'hFFFF_FFFC);
    wb2.ack = 1'b1; wb2.dat = 32'h1234_5678;
    @(negedge clk);
    wb2.ack = 1'b0;
    chk("wrap_valid", {31'b0, valid2}, 1);
    chk("wrap_ipc", ipc2, 32'hFFFF_FFFC);
    chk("wrap_inst", inst2, 32'h1234_5678);
    @(negedge clk);
    chk("wrap_idle", {31'b0, wb2.cyc}, 0);
    @(negedge clk);
    chk("wrap_adr1", wb2.adr, 32'h0000_0000);
    #2 reset = 1'b1;
    #1;
    chk("midrst_cyc", {31'b0, wb.cyc}, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    @(negedge clk);
    wb.ack = 1'b1; wb.dat = 32'hDEAD_BEEF;
    reset = 1'b0;
    @(negedge clk);
    wb.ack = 1'b0;
    chk("late_ack_valid", {31'b0, valid}, 0);
    chk("late_ack_cyc", {31'b0, wb.cyc}, 1);
    chk("late_ack_adr", wb.adr, 32'h8000_0000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
